// File: rtl/prog_loader_pkg.sv
// Shared loader types: FSM states, error codes, frame magic and the decoder's op-field position.
// Build option PROG_LOADER_CHECKSUM_EN enables the trailing checksum byte.
package pkg_loader;

  typedef enum logic [2:0] {
    MAGIC0, MAGIC1, LEN0, LEN1, DATA, CHK, DONE, ERR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MAGIC = 2'b01;
  localparam logic [1:0] ERR_LEN   = 2'b10;
  localparam logic [1:0] ERR_CHK   = 2'b11;

  localparam logic [7:0] MAGIC0_BYTE = 8'hA5;
  localparam logic [7:0] MAGIC1_BYTE = 8'h5A;

  // Operation field as the control unit decodes it.
  localparam int         OP_MSB          = 27;
  localparam int         OP_LSB          = 26;
  localparam logic [1:0] OP_FIELD_UNUSED = 2'b11;

  function automatic logic op_unused(input logic [31:0] w);
    return w[OP_MSB:OP_LSB] == OP_FIELD_UNUSED;
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs four stream bytes, LSB first, into a 32-bit word; word_ready is a combinational strobe
// on the fourth byte, with the full word on 'word' in that same cycle. Never backpressures.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  idx;
  logic [23:0] lower;

  // The fourth byte is not stored; it completes the word on the fly.
  assign word       = {byte_dat, lower};
  assign word_ready = byte_en && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= 2'd0;
      lower <= 24'd0;
    end else if (byte_en) begin
      idx   <= idx + 2'd1;
      lower <= {byte_dat, lower[23:8]};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses the framed byte stream into imem writes (one cycle after each 4th byte) and
// releases cpu_hold on success; 1 byte/cycle, s_ready drops only in DONE/ERR. Option: PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import pkg_loader::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              imem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic              op_warn,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] WC_ONE = 1;

  state_t      state, state_n;
  logic [1:0]  err_n;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_in;
  logic        bad_len;
  logic        last_word;
  logic        acc;
  logic        byte_en;
  logic [31:0] asm_word;
  logic        asm_rdy;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign acc     = s_valid && s_ready;
  assign byte_en = acc && (state == DATA);
  assign len_in  = {s_data, len_lo};
  assign bad_len = (len_in == 16'd0) || (32'(len_in) > 32'(MAX_WORDS));

  // word_count lags the write by a cycle but is current again long before the next 4th byte.
  assign last_word = (17'(word_count) + 17'd1) == {1'b0, len};

  assign s_ready  = (state != DONE) && (state != ERR);
  // Holding done off while the final write is in flight keeps the core stalled until it lands.
  assign done     = (state == DONE) && !imem_we;
  assign cpu_hold = !done;
  assign error    = (state == ERR);

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (byte_en),
    .byte_dat   (s_data),
    .word       (asm_word),
    .word_ready (asm_rdy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MAGIC0;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_n;
      err_code <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    err_n   = err_code;
    case (state)
      MAGIC0: if (acc && s_data == MAGIC0_BYTE) state_n = MAGIC1;
      MAGIC1: begin
        if (acc) begin
          if (s_data == MAGIC1_BYTE) begin
            state_n = LEN0;
          end else begin
            state_n = ERR;
            err_n   = ERR_MAGIC;
          end
        end
      end
      LEN0: if (acc) state_n = LEN1;
      LEN1: begin
        if (acc) begin
          if (bad_len) begin
            state_n = ERR;
            err_n   = ERR_LEN;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (asm_rdy && last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_n = CHK;
`else
          state_n = DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        if (acc) begin
          if (s_data == csum) begin
            state_n = DONE;
          end else begin
            state_n = ERR;
            err_n   = ERR_CHK;
          end
        end
      end
`endif
      default: state_n = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo     <= 8'd0;
      len        <= 16'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      op_warn    <= 1'b0;
      word_count <= '0;
    end else begin
      if (acc && state == LEN0) len_lo <= s_data;
      if (acc && state == LEN1) len    <= len_in;
      imem_we <= asm_rdy;
      if (asm_rdy) begin
        imem_wdata <= asm_word;
        imem_addr  <= word_count[ADDR_W-1:0];
        if (op_unused(asm_word)) op_warn <= 1'b1;
      end
      if (imem_we) word_count <= word_count + WC_ONE;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)          csum <= 8'd0;
    else if (byte_en) csum <= csum ^ s_data;
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected imem writes are queued as words are sent and
// popped as imem_we appears; status flags are checked at frame end.
module tb_prog_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        s_data = 8'd0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_we;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic              op_warn;
  logic [ADDR_W:0]   word_count;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t               sb[$];
  wr_t               exp_wr;
  logic [ADDR_W-1:0] exp_addr;
  logic [7:0]        csum;
  logic              exp_warn;
  int                n_tests = 0;
  int                n_fail  = 0;
  int                cyc     = 0;
  int                t0;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_we    (imem_we),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .op_warn    (op_warn),
    .word_count (word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (sb.size() == 0) begin
        check("unexpected_we", 64'(imem_addr), 64'hFFFF);
      end else begin
        exp_wr = sb.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(exp_wr.a));
        check("wr_data", 64'(imem_wdata), 64'(exp_wr.d));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t       = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!s_ready) check("s_ready_timeout", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic header(input logic [15:0] n);
    csum = 8'd0;
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    sb.push_back('{exp_addr, w});
    exp_addr = exp_addr + 1'b1;
    if (w[27:26] == 2'b11) exp_warn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      csum = csum ^ w[8*i +: 8];
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    sb.delete();
    exp_addr = '0;
    csum     = 8'd0;
    exp_warn = 1'b0;
  endtask

  task automatic check_reset(input string p);
    check({p, "_s_ready"},    64'(s_ready),    64'd1);
    check({p, "_cpu_hold"},   64'(cpu_hold),   64'd1);
    check({p, "_imem_addr"},  64'(imem_addr),  64'd0);
    check({p, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    check({p, "_imem_we"},    64'(imem_we),    64'd0);
    check({p, "_done"},       64'(done),       64'd0);
    check({p, "_error"},      64'(error),      64'd0);
    check({p, "_err_code"},   64'(err_code),   64'd0);
    check({p, "_op_warn"},    64'(op_warn),    64'd0);
    check({p, "_word_count"}, 64'(word_count), 64'd0);
  endtask

  // Called right after the last payload byte has been accepted.
  task automatic finish_ok(input string p, input int n);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(csum);
    s_valid = 1'b0;
    check({p, "_done_after_chk"}, 64'(done), 64'd1);
`else
    s_valid = 1'b0;
    check({p, "_last_we"},    64'(imem_we), 64'd1);
    check({p, "_done_early"}, 64'(done),    64'd0);
    @(posedge clk); #1;
    check({p, "_done"}, 64'(done), 64'd1);
`endif
    check({p, "_cpu_hold"},   64'(cpu_hold),   64'd0);
    check({p, "_word_count"}, 64'(word_count), 64'(n));
    check({p, "_op_warn"},    64'(op_warn),    64'(exp_warn));
    check({p, "_s_ready"},    64'(s_ready),    64'd0);
    check({p, "_error"},      64'(error),      64'd0);
    check({p, "_sb_left"},    64'(sb.size()),  64'd0);
  endtask

  task automatic expect_err(input string p, input logic [1:0] code);
    s_valid = 1'b0;
    check({p, "_error"},    64'(error),    64'd1);
    check({p, "_err_code"}, 64'(err_code), 64'(code));
    check({p, "_s_ready"},  64'(s_ready),  64'd0);
    check({p, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    check({p, "_done"},     64'(done),     64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_reset("rst");

    // Basic two-word load.
    header(16'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    finish_ok("basic", 2);

    // Junk before the magic is skipped.
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    header(16'd1);
    send_word(32'h00000001);
    finish_ok("resync", 1);

    // Unused op class warns but loads.
    do_reset();
    header(16'd1);
    send_word(32'h0C000000);
    finish_ok("opwarn", 1);

    do_reset();
    send_byte(8'hA5);
    send_byte(8'h33);
    expect_err("badmagic", 2'b01);

    do_reset();
    header(16'd0);
    expect_err("len0", 2'b10);

    do_reset();
    header(16'(MAX_WORDS + 1));
    expect_err("lenmax", 2'b10);
    repeat (8) @(posedge clk);
    #1;
    check("lenmax_word_count", 64'(word_count), 64'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    header(16'd1);
    send_word(32'h12345678);
    send_byte(8'h09);
    expect_err("badchk", 2'b11);
    check("badchk_sb_left", 64'(sb.size()), 64'd0);
`endif

    // Reset in the middle of the payload, then a clean reload.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h78);
    send_byte(8'h56);
    do_reset();
    check_reset("midrst");
    header(16'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    finish_ok("reload", 2);

    // Continuous valid: 36 bytes must take exactly 36 cycles.
    do_reset();
    t0 = cyc;
    header(16'd8);
    for (int i = 0; i < 8; i++) send_word($urandom);
    check("tput_cycles", 64'(cyc - t0), 64'd36);
    finish_ok("tput", 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
